// File: rtl/ccie_mem_responder.sv
// rtl/ccie_mem_responder.sv - ll_ccie memory-side responder: request FIFOs, line memory, fixed-latency responses
module ccie_mem_responder #(
  parameter int ADDR_LMT     = 20,
  parameter int MDATA        = 14,
  parameter int CACHE_WIDTH  = 512,
  parameter int MEM_LOG2     = 10,
  parameter int FIFO_LOG2    = 4,
  parameter int AFULL_MARGIN = 4,
  parameter int RD_LAT       = 4,
  parameter int WR_LAT       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_LMT-1:0]    rd_req_addr,
  input  logic [MDATA-1:0]       rd_req_mdata,
  input  logic                   rd_req_en,
  output logic                   rd_req_almostfull,
  output logic                   rd_rsp_valid,
  output logic [MDATA-1:0]       rd_rsp_mdata,
  output logic [CACHE_WIDTH-1:0] rd_rsp_data,
  input  logic [ADDR_LMT+3:0]    wr_req_addr,
  input  logic [MDATA-1:0]       wr_req_mdata,
  input  logic [CACHE_WIDTH-1:0] wr_req_data,
  input  logic                   wr_req_en,
  input  logic                   wr_req_now,
  input  logic                   wr_req_direct,
  output logic                   wr_req_almostfull,
  output logic                   wr_rsp_valid,
  output logic                   wr_rsp_rvalid,
  input  logic                   rsp_throttle,
  output logic [1:0]             err
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int LINES = 1 << MEM_LOG2;
  localparam logic [FIFO_LOG2:0] FULL_CNT  = (FIFO_LOG2+1)'(DEPTH);
  localparam logic [FIFO_LOG2:0] AFULL_CNT = (FIFO_LOG2+1)'(DEPTH - AFULL_MARGIN);

  // Line storage; deliberately never reset so contents survive a mid-run reset
  logic [CACHE_WIDTH-1:0] mem [LINES];

  logic [ADDR_LMT-1:0]  rd_fifo_addr  [DEPTH];
  logic [MDATA-1:0]     rd_fifo_mdata [DEPTH];
  logic [FIFO_LOG2-1:0] rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d;
  logic [FIFO_LOG2:0]   rd_cnt_q, rd_cnt_d;
  logic                 rd_afull_q, rd_afull_d;
  logic                 rd_full, rd_push, rd_pop;

  logic [ADDR_LMT+3:0]    wr_fifo_addr  [DEPTH];
  logic [MDATA-1:0]       wr_fifo_mdata [DEPTH];
  logic [CACHE_WIDTH-1:0] wr_fifo_data  [DEPTH];
  logic                   wr_fifo_dir   [DEPTH];
  logic [FIFO_LOG2-1:0]   wr_wptr_q, wr_wptr_d, wr_rptr_q, wr_rptr_d;
  logic [FIFO_LOG2:0]     wr_cnt_q, wr_cnt_d;
  logic                   wr_afull_q, wr_afull_d;
  logic                   wr_strobe, wr_full, wr_push, wr_pop;

  logic [1:0] err_q, err_d;

  logic [ADDR_LMT-1:0]    rd_head_addr;
  logic [MDATA-1:0]       rd_head_mdata;
  logic [ADDR_LMT+3:0]    wr_head_addr;
  logic [MDATA-1:0]       wr_head_mdata;
  logic [CACHE_WIDTH-1:0] wr_head_data;
  logic                   wr_head_dir;
  logic [MEM_LOG2-1:0]    rd_idx, wr_idx;
  logic [3:0]             wr_dw;
  logic [CACHE_WIDTH-1:0] wr_line;

  logic [RD_LAT-1:0]                  rd_vld_q, rd_vld_d;
  logic [RD_LAT-1:0][MDATA-1:0]       rd_tag_q, rd_tag_d;
  logic [RD_LAT-1:0][CACHE_WIDTH-1:0] rd_dat_q, rd_dat_d;
  logic [WR_LAT-1:0]                  wr_vld_q, wr_vld_d;
  logic [WR_LAT-1:0]                  wr_dir_q, wr_dir_d;

  assign rd_head_addr  = rd_fifo_addr[rd_rptr_q];
  assign rd_head_mdata = rd_fifo_mdata[rd_rptr_q];
  assign wr_head_addr  = wr_fifo_addr[wr_rptr_q];
  assign wr_head_mdata = wr_fifo_mdata[wr_rptr_q];
  assign wr_head_data  = wr_fifo_data[wr_rptr_q];
  assign wr_head_dir   = wr_fifo_dir[wr_rptr_q];

  // Upper address bits wrap away; the write tag and flush hint are accepted but never consumed
  assign rd_idx = rd_head_addr[MEM_LOG2-1:0];
  assign wr_idx = wr_head_addr[MEM_LOG2+3:4];
  assign wr_dw  = wr_head_addr[3:0];

  logic unused_ok;
  assign unused_ok = ^{rd_head_addr[ADDR_LMT-1:MEM_LOG2], wr_head_addr[ADDR_LMT+3:MEM_LOG2+4],
                       wr_head_mdata, wr_req_now};

  // Read FIFO control: pops only from registered occupancy, so a fresh push waits a cycle
  always_comb begin
    rd_full   = (rd_cnt_q == FULL_CNT);
    rd_push   = rd_req_en && !rd_full;
    rd_pop    = !rsp_throttle && (rd_cnt_q != '0);
    rd_wptr_d = rd_push ? rd_wptr_q + 1'b1 : rd_wptr_q;
    rd_rptr_d = rd_pop ? rd_rptr_q + 1'b1 : rd_rptr_q;
    rd_cnt_d  = rd_cnt_q;
    if (rd_push && !rd_pop) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end else if (!rd_push && rd_pop) begin
      rd_cnt_d = rd_cnt_q - 1'b1;
    end
    rd_afull_d = (rd_cnt_d >= AFULL_CNT);
  end

  // Write FIFO control: either strobe enqueues one entry
  always_comb begin
    wr_strobe = wr_req_en || wr_req_direct;
    wr_full   = (wr_cnt_q == FULL_CNT);
    wr_push   = wr_strobe && !wr_full;
    wr_pop    = !rsp_throttle && (wr_cnt_q != '0);
    wr_wptr_d = wr_push ? wr_wptr_q + 1'b1 : wr_wptr_q;
    wr_rptr_d = wr_pop ? wr_rptr_q + 1'b1 : wr_rptr_q;
    wr_cnt_d  = wr_cnt_q;
    if (wr_push && !wr_pop) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end else if (!wr_push && wr_pop) begin
      wr_cnt_d = wr_cnt_q - 1'b1;
    end
    wr_afull_d = (wr_cnt_d >= AFULL_CNT);
  end

  // Sticky error flags: overflow on either FIFO, conflicting write strobes
  always_comb begin
    err_d = err_q;
    if ((rd_req_en && rd_full) || (wr_strobe && wr_full)) begin
      err_d[0] = 1'b1;
    end
    if (wr_req_en && wr_req_direct) begin
      err_d[1] = 1'b1;
    end
  end

  // New line image for the head write: whole line, or one dword merged into the old line
  always_comb begin
    wr_line = mem[wr_idx];
    if (wr_head_dir) begin
      wr_line = wr_head_data;
    end else begin
      wr_line[{wr_dw, 5'b00000} +: 32] = wr_head_data[31:0];
    end
  end

  // Latency pipelines; read data is sampled before this cycle's write lands (read-before-write)
  always_comb begin
    rd_vld_d    = '0;
    rd_tag_d    = '0;
    rd_dat_d    = '0;
    wr_vld_d    = '0;
    wr_dir_d    = '0;
    rd_vld_d[0] = rd_pop;
    rd_tag_d[0] = rd_head_mdata;
    rd_dat_d[0] = mem[rd_idx];
    for (int i = 1; i < RD_LAT; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
      rd_tag_d[i] = rd_tag_q[i-1];
      rd_dat_d[i] = rd_dat_q[i-1];
    end
    wr_vld_d[0] = wr_pop;
    wr_dir_d[0] = wr_head_dir;
    for (int i = 1; i < WR_LAT; i++) begin
      wr_vld_d[i] = wr_vld_q[i-1];
      wr_dir_d[i] = wr_dir_q[i-1];
    end
  end

  // FIFO payload storage; only pointers and counts are reset
  always_ff @(posedge clk) begin
    if (rd_push) begin
      rd_fifo_addr[rd_wptr_q]  <= rd_req_addr;
      rd_fifo_mdata[rd_wptr_q] <= rd_req_mdata;
    end
    if (wr_push) begin
      wr_fifo_addr[wr_wptr_q]  <= wr_req_addr;
      wr_fifo_mdata[wr_wptr_q] <= wr_req_mdata;
      wr_fifo_data[wr_wptr_q]  <= wr_req_data;
      wr_fifo_dir[wr_wptr_q]   <= wr_req_direct;
    end
  end

  // Apply the dequeued write; blocked during reset so a flushed entry never lands
  always_ff @(posedge clk) begin
    if (wr_pop && !rst) begin
      mem[wr_idx] <= wr_line;
    end
  end

  // State registers: pointers, counts, flags and both latency pipelines
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_wptr_q  <= '0;
      rd_rptr_q  <= '0;
      rd_cnt_q   <= '0;
      rd_afull_q <= 1'b0;
      wr_wptr_q  <= '0;
      wr_rptr_q  <= '0;
      wr_cnt_q   <= '0;
      wr_afull_q <= 1'b0;
      err_q      <= '0;
      rd_vld_q   <= '0;
      rd_tag_q   <= '0;
      rd_dat_q   <= '0;
      wr_vld_q   <= '0;
      wr_dir_q   <= '0;
    end else begin
      rd_wptr_q  <= rd_wptr_d;
      rd_rptr_q  <= rd_rptr_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_afull_q <= rd_afull_d;
      wr_wptr_q  <= wr_wptr_d;
      wr_rptr_q  <= wr_rptr_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_afull_q <= wr_afull_d;
      err_q      <= err_d;
      rd_vld_q   <= rd_vld_d;
      rd_tag_q   <= rd_tag_d;
      rd_dat_q   <= rd_dat_d;
      wr_vld_q   <= wr_vld_d;
      wr_dir_q   <= wr_dir_d;
    end
  end

  assign rd_req_almostfull = rd_afull_q;
  assign wr_req_almostfull = wr_afull_q;
  assign rd_rsp_valid      = rd_vld_q[RD_LAT-1];
  assign rd_rsp_mdata      = rd_tag_q[RD_LAT-1];
  assign rd_rsp_data       = rd_dat_q[RD_LAT-1];
  assign wr_rsp_valid      = wr_vld_q[WR_LAT-1] & ~wr_dir_q[WR_LAT-1];
  assign wr_rsp_rvalid     = wr_vld_q[WR_LAT-1] & wr_dir_q[WR_LAT-1];
  assign err               = err_q;

endmodule

// File: tb/tb_ccie_mem_responder.sv
// tb/tb_ccie_mem_responder.sv - directed vector bench for ccie_mem_responder
module tb_ccie_mem_responder;
  localparam int AL = 20;
  localparam int MD = 14;
  localparam int CW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic [AL-1:0] rd_req_addr;
  logic [MD-1:0] rd_req_mdata;
  logic          rd_req_en;
  logic          rd_req_almostfull;
  logic          rd_rsp_valid;
  logic [MD-1:0] rd_rsp_mdata;
  logic [CW-1:0] rd_rsp_data;
  logic [AL+3:0] wr_req_addr;
  logic [MD-1:0] wr_req_mdata;
  logic [CW-1:0] wr_req_data;
  logic          wr_req_en;
  logic          wr_req_now;
  logic          wr_req_direct;
  logic          wr_req_almostfull;
  logic          wr_rsp_valid;
  logic          wr_rsp_rvalid;
  logic          rsp_throttle;
  logic [1:0]    err;

  always #5 clk = ~clk;

  ccie_mem_responder dut (
    .clk(clk), .rst(rst),
    .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata), .rd_req_en(rd_req_en),
    .rd_req_almostfull(rd_req_almostfull), .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
    .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata), .wr_req_data(wr_req_data),
    .wr_req_en(wr_req_en), .wr_req_now(wr_req_now), .wr_req_direct(wr_req_direct),
    .wr_req_almostfull(wr_req_almostfull), .wr_rsp_valid(wr_rsp_valid),
    .wr_rsp_rvalid(wr_rsp_rvalid), .rsp_throttle(rsp_throttle), .err(err)
  );

  typedef struct {
    logic          rd_en;
    logic [AL-1:0] rd_addr;
    logic [MD-1:0] rd_tag;
    logic          wr_en;
    logic          wr_dir;
    logic [AL+3:0] wr_addr;
    logic [CW-1:0] wr_data;
    logic          e_rv;
    logic [MD-1:0] e_tag;
    logic [CW-1:0] e_dat;
    logic          e_wv;
    logic          e_wrv;
    logic [1:0]    e_err;
  } vec_t;

  vec_t vt[$];
  int checks = 0;
  int errors = 0;

  logic [CW-1:0] d_hdr, d_f, d_merge, d_12, d_a, d_b, d_w;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic re, input logic [AL-1:0] ra, input logic [MD-1:0] rt,
                     input logic we, input logic wd, input logic [AL+3:0] wa, input logic [CW-1:0] wdat,
                     input logic erv, input logic [MD-1:0] et, input logic [CW-1:0] ed,
                     input logic ewv, input logic ewrv, input logic [1:0] eerr);
    vec_t v;
    v.rd_en = re;  v.rd_addr = ra; v.rd_tag = rt;
    v.wr_en = we;  v.wr_dir = wd;  v.wr_addr = wa; v.wr_data = wdat;
    v.e_rv = erv;  v.e_tag = et;   v.e_dat = ed;
    v.e_wv = ewv;  v.e_wrv = ewrv; v.e_err = eerr;
    vt.push_back(v);
  endtask

  task automatic idle(input logic erv, input logic [MD-1:0] et, input logic [CW-1:0] ed,
                      input logic ewv, input logic ewrv, input logic [1:0] eerr);
    add(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, erv, et, ed, ewv, ewrv, eerr);
  endtask

  task automatic check1(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string name);
    check1({name, "_ctl"}, {rd_req_almostfull, rd_rsp_valid, rd_rsp_mdata, wr_req_almostfull,
                            wr_rsp_valid, wr_rsp_rvalid, err}, '0);
    check1({name, "_data"}, rd_rsp_data, '0);
  endtask

  task automatic read_line(input logic [AL-1:0] a, input logic [MD-1:0] t,
                           input logic [CW-1:0] exp, input string name);
    int n;
    rd_req_addr = a; rd_req_mdata = t; rd_req_en = 1'b1;
    tick();
    rd_req_en = 1'b0;
    n = 0;
    while (!rd_rsp_valid && n < 12) begin
      tick();
      n++;
    end
    check1({name, "_latency"}, n, 4);
    check1({name, "_tag"}, {rd_rsp_valid, rd_rsp_mdata}, {1'b1, t});
    check1({name, "_data"}, rd_rsp_data, exp);
    tick();
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1; rd_req_addr = '0; rd_req_mdata = '0; rd_req_en = 1'b0;
    wr_req_addr = '0; wr_req_mdata = '0; wr_req_data = '0; wr_req_en = 1'b0;
    wr_req_now = 1'b0; wr_req_direct = 1'b0; rsp_throttle = 1'b0;

    d_hdr = '0; d_hdr[95:0] = {32'd5, 32'd4, 32'd3};
    d_f = '1;
    d_merge = '1; d_merge[127:96] = 32'h12;
    d_12 = '0; d_12[31:0] = 32'h12;
    d_a = '0; d_a[31:0] = 32'hA;
    d_b = '0; d_b[31:0] = 32'hB;
    d_w = '0; d_w[63:0] = 64'h12345678_00005A5A;

    // header readback
    add(0, '0, '0, 0, 1, 24'h0, d_hdr, 0, '0, '0, 0, 0, 2'b00);
    add(1, 20'h0, 14'h2A, 0, 0, '0, '0, 0, '0, '0, 0, 0, 2'b00);
    idle(0, '0, '0, 0, 1, 2'b00);
    idle(0, '0, '0, 0, 0, 2'b00);
    idle(0, '0, '0, 0, 0, 2'b00);
    idle(1, 14'h2A, d_hdr, 0, 0, 2'b00);
    idle(0, '0, '0, 0, 0, 2'b00);
    // dword merge
    add(0, '0, '0, 0, 1, 24'h70, d_f, 0, '0, '0, 0, 0, 2'b00);
    add(0, '0, '0, 1, 0, 24'h73, d_12, 0, '0, '0, 0, 0, 2'b00);
    add(1, 20'h7, 14'h07, 0, 0, '0, '0, 0, '0, '0, 0, 1, 2'b00);
    idle(0, '0, '0, 1, 0, 2'b00);
    idle(0, '0, '0, 0, 0, 2'b00);
    idle(0, '0, '0, 0, 0, 2'b00);
    idle(1, 14'h07, d_merge, 0, 0, 2'b00);
    // same-cycle hazard on line 9
    add(0, '0, '0, 0, 1, 24'h90, d_a, 0, '0, '0, 0, 0, 2'b00);
    idle(0, '0, '0, 0, 0, 2'b00);
    add(1, 20'h9, 14'h11, 0, 1, 24'h90, d_b, 0, '0, '0, 0, 1, 2'b00);
    add(1, 20'h9, 14'h12, 0, 0, '0, '0, 0, '0, '0, 0, 0, 2'b00);
    idle(0, '0, '0, 0, 1, 2'b00);
    idle(0, '0, '0, 0, 0, 2'b00);
    idle(1, 14'h11, d_a, 0, 0, 2'b00);
    idle(1, 14'h12, d_b, 0, 0, 2'b00);
    idle(0, '0, '0, 0, 0, 2'b00);
    // wrap plus conflicting strobes
    add(0, '0, '0, 1, 1, 24'h4050, d_w, 0, '0, '0, 0, 0, 2'b10);
    idle(0, '0, '0, 0, 0, 2'b10);
    add(1, 20'h5, 14'h05, 0, 0, '0, '0, 0, '0, '0, 0, 1, 2'b10);
    idle(0, '0, '0, 0, 0, 2'b10);
    idle(0, '0, '0, 0, 0, 2'b10);
    idle(0, '0, '0, 0, 0, 2'b10);
    idle(1, 14'h05, d_w, 0, 0, 2'b10);
    idle(0, '0, '0, 0, 0, 2'b10);

    tick();
    tick();
    check_quiet("reset_state");
    rst = 1'b0;

    foreach (vt[i]) begin
      rd_req_en = vt[i].rd_en; rd_req_addr = vt[i].rd_addr; rd_req_mdata = vt[i].rd_tag;
      wr_req_en = vt[i].wr_en; wr_req_direct = vt[i].wr_dir; wr_req_addr = vt[i].wr_addr;
      wr_req_data = vt[i].wr_data; wr_req_mdata = 14'(i); wr_req_now = vt[i].wr_en;
      tick();
      checks++;
      if (rd_rsp_valid !== vt[i].e_rv || wr_rsp_valid !== vt[i].e_wv ||
          wr_rsp_rvalid !== vt[i].e_wrv || err !== vt[i].e_err ||
          (vt[i].e_rv && (rd_rsp_mdata !== vt[i].e_tag || rd_rsp_data !== vt[i].e_dat))) begin
        errors++;
        $display("FAIL row%0d: got rv=%b tag=%h wv=%b wrv=%b err=%b data=%h want rv=%b tag=%h wv=%b wrv=%b err=%b data=%h",
                 i, rd_rsp_valid, rd_rsp_mdata, wr_rsp_valid, wr_rsp_rvalid, err, rd_rsp_data,
                 vt[i].e_rv, vt[i].e_tag, vt[i].e_wv, vt[i].e_wrv, vt[i].e_err, vt[i].e_dat);
      end
    end
    rd_req_en = 1'b0; wr_req_en = 1'b0; wr_req_direct = 1'b0; wr_req_now = 1'b0;

    // backpressure: fill under throttle, overflow, then drain
    rst = 1'b1;
    tick();
    check_quiet("reset_clears_err");
    rst = 1'b0;
    rsp_throttle = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rd_req_en = 1'b1; rd_req_addr = AL'(i); rd_req_mdata = 14'(256 + i);
      tick();
      if (i == 10) check1("afull_at11", rd_req_almostfull, 1'b0);
      if (i == 11) check1("afull_at12", rd_req_almostfull, 1'b1);
      if (i == 15) check1("no_ovf_at16", err, 2'b00);
      if (i == 16) check1("ovf_err", err, 2'b01);
    end
    rd_req_en = 1'b0;
    rsp_throttle = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!rd_rsp_valid && n < 10);
    check1("release_latency", n, 4);
    for (int j = 0; j < 16; j++) begin
      check1($sformatf("bp_rsp%0d", j), {rd_rsp_valid, rd_rsp_mdata}, {1'b1, 14'(256 + j)});
      tick();
    end
    check1("bp_after16", rd_rsp_valid, 1'b0);

    // reset with reads in flight
    for (int i = 0; i < 3; i++) begin
      rd_req_en = 1'b1; rd_req_addr = 20'h9; rd_req_mdata = 14'(32 + i);
      tick();
    end
    rd_req_en = 1'b0;
    rst = 1'b1;
    tick();
    check_quiet("reset_inflight");
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rd_rsp_valid) seen++;
    end
    check1("no_rsp_after_reset", seen, 0);
    read_line(20'h9, 14'h33, d_b, "retain9");
    read_line(20'h7, 14'h34, d_merge, "retain7");
    read_line(20'h405, 14'h35, d_w, "retain5_wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ccie_mem_responder.md
Name: ccie_mem_responder

Overview:
- Memory-side responder for the accelerator request/response interface used by the ll_ccie test AFUs.
- Accepts cache-line read requests, and dword or full-line write requests, from an AFU.
- Services requests from an internal cache-line memory and returns tagged read data and write completions with fixed latency.
- Drives almostfull backpressure. Serves as the synthesizable far end for AFU simulation and bring-up.

Parameters:
- ADDR_LMT, 20, read line-address width; write address is ADDR_LMT+4 bits (line address plus dword index).
- MDATA, 14, request tag width, echoed on read responses.
- CACHE_WIDTH, 512, line width in bits (16 dwords of 32 bits).
- MEM_LOG2, 10, log2 of memory depth in lines.
- FIFO_LOG2, 4, log2 of each request FIFO depth.
- AFULL_MARGIN, 4, free-slot count at which almostfull asserts.
- RD_LAT, 4, cycles from read dequeue to rd_rsp_valid (minimum 1).
- WR_LAT, 2, cycles from write dequeue to write response (minimum 1).

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- rd_req_addr, in, ADDR_LMT, read line address.
- rd_req_mdata, in, MDATA, read tag.
- rd_req_en, in, 1, read request strobe.
- rd_req_almostfull, out, 1, read FIFO nearly full.
- rd_rsp_valid, out, 1, read data valid.
- rd_rsp_mdata, out, MDATA, echoed read tag.
- rd_rsp_data, out, CACHE_WIDTH, read line data.
- wr_req_addr, in, ADDR_LMT+4, bits [ADDR_LMT+3:4] are the line address; bits [3:0] are the dword index.
- wr_req_mdata, in, MDATA, write tag; stored, not returned.
- wr_req_data, in, CACHE_WIDTH, write data.
- wr_req_en, in, 1, dword write strobe.
- wr_req_now, in, 1, flush hint; accepted, no effect on storage.
- wr_req_direct, in, 1, full-line write strobe.
- wr_req_almostfull, out, 1, write FIFO nearly full.
- wr_rsp_valid, out, 1, dword write completion.
- wr_rsp_rvalid, out, 1, full-line write completion.
- rsp_throttle, in, 1, when high, neither FIFO dequeues (test backpressure).
- err, out, 2, sticky error flags: bit0 = FIFO overflow, bit1 = en and direct asserted together.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset:
  - All outputs go to 0 on the cycle after rst is sampled high.
  - Both FIFOs flush, both latency pipelines clear, and err clears.
  - Memory contents are not reset; memory is retained across a mid-operation reset.
  - In-flight responses are discarded and no response is issued for them.
- Read enqueue:
  - rd_req_en high pushes {addr, mdata} into the read FIFO.
  - Enqueue is permitted while almostfull is high.
  - If the FIFO is full, the request is dropped and err[0] sets.
- Write enqueue:
  - wr_req_en or wr_req_direct high pushes {addr, data, type} into the write FIFO.
  - If both strobes are high in the same cycle, the entry is a direct write and err[1] sets.
  - If the FIFO is full, the request is dropped and err[0] sets.
- Almostfull:
  - Asserted when the FIFO occupancy is at least 2^FIFO_LOG2 - AFULL_MARGIN.
  - Registered: it reflects occupancy at the end of the previous cycle.
- Dequeue:
  - When rsp_throttle is low, each non-empty FIFO pops one entry per cycle.
  - The read and write FIFOs operate independently.
  - A push and a pop in the same cycle leave the occupancy unchanged.
  - A push into an empty FIFO may be popped no earlier than the next cycle.
- Address mapping: memory index is the line address modulo 2^MEM_LOG2 (upper bits ignored, so addresses wrap).
- Read service:
  - The line is sampled at dequeue.
  - rd_rsp_valid, mdata and data appear exactly RD_LAT cycles later.
  - Responses return in request order; at most one response per cycle.
- Write service, applied to memory at dequeue:
  - Dword write: dword[idx] = wr_req_data[31:0]; all other dwords of the line are unchanged.
  - Direct write: whole line = wr_req_data.
  - wr_rsp_valid (dword write) or wr_rsp_rvalid (direct write) pulses one cycle, exactly WR_LAT cycles after dequeue.
  - The two completion signals are never high in the same cycle.
- Read/write to the same line dequeued in the same cycle: the read returns pre-write data.
  - A read dequeued the cycle after the write returns post-write data.
- Throttle: rsp_throttle does not freeze the latency pipelines; responses already in flight still emerge on schedule.
- Ordering: no ordering is guaranteed between the read stream and the write stream beyond the same-cycle rule above.

Test Plan:
- Header readback: direct write line 0 with dwords {3,4,5}, then read line 0 with mdata=0x2A. Required: wr_rsp_rvalid pulses WR_LAT=2 cycles after dequeue; rd_rsp_data[95:0] = {5,4,3} and rd_rsp_mdata = 0x2A, RD_LAT=4 cycles after the read dequeues.
- Dword merge: direct write line 7 = all 0xFFFFFFFF, then dword write addr (7<<4)|3 with data 0x12. Required: a read of line 7 returns dword3 = 0x12 and the other 15 dwords = 0xFFFFFFFF; wr_rsp_valid pulses once.
- Backpressure: rsp_throttle=1 and 12 reads pushed. Required: rd_req_almostfull asserts the cycle after occupancy reaches 12.
  - A further 4 reads fill the FIFO; a 17th read sets err[0].
  - Releasing throttle yields 16 responses on 16 consecutive cycles, in order, with tags matching.
- Same-cycle hazard: line 9 = 0xA then 0xB, with the read and the write of line 9 dequeued together. Required: the read returns 0xA; a read in the next cycle returns 0xB.
- Wrap and error: write line 2^MEM_LOG2+5 and read line 5; the read returns the written data. Asserting wr_req_en and wr_req_direct together sets err[1] and performs a full-line write.
- Mid-operation reset: assert rst with 3 reads in flight. Required: no rd_rsp_valid follows; all outputs and err are 0; memory data written before reset reads back intact.
